// File: rtl/sprite_arb_pkg.sv
// Shared types and defaults for the sprite ROM arbiter and its round-robin picker.
// Optional fixed priority for requester 0 is enabled by defining SPRITE_ARB_PRIO_EN.
package sprite_arb_pkg;

    localparam int N_REQ_DEF   = 4;
    localparam int AW_DEF      = 12;
    localparam int DW_DEF      = 4;
    localparam int ROM_LAT_DEF = 1;
    localparam int N_REQ_MAX   = 8;
    localparam int ID_W_MAX    = $clog2(N_REQ_MAX);

    typedef logic [$clog2(N_REQ_DEF)-1:0] req_id_t;

    // The id field is sized for the largest supported requester count.
    typedef struct packed {
        logic                valid;
        logic [ID_W_MAX-1:0] id;
    } tag_t;

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after ptr, wrapping.
// Under SPRITE_ARB_PRIO_EN the caller clears mask[0] so index 0 never wins here.
module rr_pick
    import sprite_arb_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEF,
    localparam int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    input  logic [N_REQ-1:0] mask,
    output logic             found,
    output logic [PW-1:0]    idx
);

    logic [N_REQ-1:0] eligible;
    logic [PW:0]      cand;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_elig
            assign eligible[gi] = req[gi] & mask[gi];
        end
    endgenerate

    // Walk the search order backwards so the nearest candidate to ptr is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (PW+1)'(k);
            if (cand >= (PW+1)'(N_REQ)) begin
                cand = cand - (PW+1)'(N_REQ);
            end
            if (eligible[cand[PW-1:0]]) begin
                found = 1'b1;
                idx   = cand[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous sprite ROM port among N_REQ renderers, returning tagged read data.
// Define SPRITE_ARB_PRIO_EN to give requester 0 absolute priority over the round-robin group.
module sprite_rom_arbiter
    import sprite_arb_pkg::*;
#(
    parameter  int N_REQ   = N_REQ_DEF,
    parameter  int AW      = AW_DEF,
    parameter  int DW      = DW_DEF,
    parameter  int ROM_LAT = ROM_LAT_DEF,
    localparam int PW      = $clog2(N_REQ)
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic              frame_start,
    input  logic              en,
    input  logic [N_REQ-1:0]  req,
    input  logic [N_REQ*AW-1:0] addr,
    output logic [N_REQ-1:0]  gnt,
    output logic [AW-1:0]     rom_address,
    input  logic [DW-1:0]     rom_q,
    output logic              rd_valid,
    output logic [PW-1:0]     rd_id,
    output logic [DW-1:0]     rd_data,
    output logic              busy
);

    logic [AW-1:0]    addr_arr [N_REQ];
    logic [N_REQ-1:0] pick_mask;
    logic             pick_found;
    logic [PW-1:0]    pick_idx;

    logic             win_valid;
    logic [PW-1:0]    win_id;
    logic             ptr_adv;
    logic [PW-1:0]    ptr_next;

    logic [N_REQ-1:0] gnt_reg;
    logic [AW-1:0]    rom_address_reg;
    logic [PW-1:0]    gnt_id_reg;
    logic [PW-1:0]    ptr_reg;
    tag_t             pipe_reg [ROM_LAT];
    tag_t             tag_out;
    logic             pipe_any;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_addr
            assign addr_arr[gi] = addr[gi*AW +: AW];
        end
    endgenerate

`ifdef SPRITE_ARB_PRIO_EN
    assign pick_mask = {{(N_REQ-1){1'b1}}, 1'b0};
`else
    assign pick_mask = '1;
`endif

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_reg),
        .mask  (pick_mask),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        win_valid = en & pick_found;
        win_id    = pick_idx;
        ptr_adv   = win_valid;
`ifdef SPRITE_ARB_PRIO_EN
        // The player tank bypasses the rotation and leaves the pointer alone.
        if (req[0]) begin
            win_valid = en;
            win_id    = '0;
            ptr_adv   = 1'b0;
        end
`endif
        if (win_id == PW'(N_REQ - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = win_id + 1'b1;
        end
`ifdef SPRITE_ARB_PRIO_EN
        if (ptr_next == '0) begin
            ptr_next = PW'(1);
        end
`endif
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt_reg         <= '0;
            rom_address_reg <= '0;
            gnt_id_reg      <= '0;
            ptr_reg         <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                pipe_reg[i] <= '0;
            end
        end else begin
            gnt_reg <= win_valid ? (N_REQ'(1) << win_id) : '0;
            if (win_valid) begin
                rom_address_reg <= addr_arr[win_id];
                gnt_id_reg      <= win_id;
            end
            if (frame_start) begin
                ptr_reg <= '0;
            end else if (ptr_adv) begin
                ptr_reg <= ptr_next;
            end
            // Stage 0 captures the grant cycle, aligning the tag with rom_q after ROM_LAT.
            pipe_reg[0] <= '{valid: |gnt_reg, id: ID_W_MAX'(gnt_id_reg)};
            for (int i = 1; i < ROM_LAT; i++) begin
                pipe_reg[i] <= pipe_reg[i-1];
            end
        end
    end

    always_comb begin
        pipe_any = 1'b0;
        for (int i = 0; i < ROM_LAT; i++) begin
            pipe_any = pipe_any | pipe_reg[i].valid;
        end
    end

    assign tag_out     = pipe_reg[ROM_LAT-1];
    assign gnt         = gnt_reg;
    assign rom_address = rom_address_reg;
    assign rd_valid    = tag_out.valid;
    assign rd_id       = PW'(tag_out.id);
    assign rd_data     = rom_q;
    assign busy        = (|gnt_reg) | pipe_any;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: one DUT with ROM_LAT=1 and one with ROM_LAT=2 share stimulus.
// Build with SPRITE_ARB_PRIO_EN defined to exercise the requester-0 priority path.
module tb_sprite_rom_arbiter;

    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 4;

    logic            vga_clk = 1'b0;
    logic            reset_n;
    logic            frame_start;
    logic            en;
    logic [N-1:0]    req;
    logic [N*AW-1:0] addr;

    logic [N-1:0]  gnt1, gnt2;
    logic [AW-1:0] rom_address1, rom_address2;
    logic [DW-1:0] rom_q1 = '0, rom_q2 = '0, rom_s2 = '0;
    logic          rd_valid1, rd_valid2;
    logic [1:0]    rd_id1, rd_id2;
    logic [DW-1:0] rd_data1, rd_data2;
    logic          busy1, busy2;

    int n_vec = 0;
    int n_err = 0;

    always #5 vga_clk = ~vga_clk;

    sprite_rom_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .ROM_LAT(1)) u_dut1 (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .en          (en),
        .req         (req),
        .addr        (addr),
        .gnt         (gnt1),
        .rom_address (rom_address1),
        .rom_q       (rom_q1),
        .rd_valid    (rd_valid1),
        .rd_id       (rd_id1),
        .rd_data     (rd_data1),
        .busy        (busy1)
    );

    sprite_rom_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .ROM_LAT(2)) u_dut2 (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .en          (en),
        .req         (req),
        .addr        (addr),
        .gnt         (gnt2),
        .rom_address (rom_address2),
        .rom_q       (rom_q2),
        .rd_valid    (rd_valid2),
        .rd_id       (rd_id2),
        .rd_data     (rd_data2),
        .busy        (busy2)
    );

    function automatic logic [DW-1:0] romf(input logic [AW-1:0] a);
        return a[3:0] ^ a[7:4] ^ a[11:8];
    endfunction

    always @(posedge vga_clk) begin
        rom_q1 <= romf(rom_address1);
        rom_s2 <= romf(rom_address2);
        rom_q2 <= rom_s2;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        addr[i*AW +: AW] = a;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        logic [AW-1:0] av [N];
        av[0] = 12'h012; av[1] = 12'h034; av[2] = 12'h056; av[3] = 12'h078;
        reset_n = 1'b0; frame_start = 1'b0; en = 1'b1; req = '0; addr = '0;

        // reset state
        tick(); tick();
        chk("rst_gnt",      32'(gnt1), 32'h0);
        chk("rst_addr",     32'(rom_address1), 32'h0);
        chk("rst_rd_valid", 32'(rd_valid1), 32'h0);
        chk("rst_rd_id",    32'(rd_id1), 32'h0);
        chk("rst_busy",     32'(busy1), 32'h0);
        chk("rst_busy2",    32'(busy2), 32'h0);
        reset_n = 1'b1;

        // single requester
        set_addr(1, 12'h0A5);
        req = 4'b0010;
        tick();
        chk("single_gnt",   32'(gnt1), 32'h2);
        chk("single_addr",  32'(rom_address1), 32'h0A5);
        chk("single_busy",  32'(busy1), 32'h1);
        chk("single_gnt2",  32'(gnt2), 32'h2);
        req = '0;
        tick();
        chk("single_gnt_off", 32'(gnt1), 32'h0);
        chk("single_valid",   32'(rd_valid1), 32'h1);
        chk("single_id",      32'(rd_id1), 32'h1);
        chk("single_data",    32'(rd_data1), 32'(romf(12'h0A5)));
        chk("single_valid2_early", 32'(rd_valid2), 32'h0);
        tick();
        chk("single_valid_off", 32'(rd_valid1), 32'h0);
        chk("single_valid2",    32'(rd_valid2), 32'h1);
        chk("single_id2",       32'(rd_id2), 32'h1);
        chk("single_data2",     32'(rd_data2), 32'(romf(12'h0A5)));

        do_reset();
        for (int i = 0; i < N; i++) set_addr(i, av[i]);

`ifdef SPRITE_ARB_PRIO_EN
        req = 4'hF;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("prio_gnt0", 32'(gnt1), 32'h1);
        end
        req = 4'hE;
        tick(); chk("prio_rr1", 32'(gnt1), 32'h2);
        tick(); chk("prio_rr2", 32'(gnt1), 32'h4);
        tick(); chk("prio_rr3", 32'(gnt1), 32'h8);
        tick(); chk("prio_rr1b", 32'(gnt1), 32'h2);
        req = '0;
        tick(); tick(); tick();
`else
        // all four requesting: strict rotation and one tagged read per grant
        req = 4'hF;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr_gnt",  32'(gnt1), 32'(1 << (k % 4)));
            chk("rr_addr", 32'(rom_address1), 32'(av[k % 4]));
            chk("rr_gnt2", 32'(gnt2), 32'(1 << (k % 4)));
            if (k > 0) begin
                chk("rr_valid", 32'(rd_valid1), 32'h1);
                chk("rr_id",    32'(rd_id1), 32'((k - 1) % 4));
                chk("rr_data",  32'(rd_data1), 32'(romf(av[(k - 1) % 4])));
            end
        end
        req = '0;
        tick();
        chk("rr_last_gnt",   32'(gnt1), 32'h0);
        chk("rr_last_valid", 32'(rd_valid1), 32'h1);
        chk("rr_last_id",    32'(rd_id1), 32'h3);
        tick();
        chk("rr_drained", 32'(rd_valid1), 32'h0);

        // en low: pipeline drains, pointer resumes where it stopped
        req = 4'hF;
        tick();
        chk("en_pre_gnt", 32'(gnt1), 32'h1);
        en = 1'b0;
        tick();
        chk("en_off_gnt1",  32'(gnt1), 32'h0);
        chk("en_off_valid", 32'(rd_valid1), 32'h1);
        chk("en_off_id",    32'(rd_id1), 32'h0);
        tick();
        chk("en_off_gnt2",   32'(gnt1), 32'h0);
        chk("en_off_valid2", 32'(rd_valid2), 32'h1);
        tick();
        chk("en_off_gnt3", 32'(gnt1), 32'h0);
        chk("en_off_busy", 32'(busy1), 32'h0);
        en = 1'b1;
        tick();
        chk("en_resume", 32'(gnt1), 32'h2);

        // frame_start alongside a grant to requester 2
        frame_start = 1'b1;
        tick();
        chk("fs_gnt2", 32'(gnt1), 32'h4);
        frame_start = 1'b0;
        tick();
        chk("fs_next0", 32'(gnt1), 32'h1);
        req = '0;
        tick(); tick(); tick();
`endif

        // reset while a ROM_LAT=2 read is being returned
        set_addr(2, 12'h3C9);
        req = 4'b0100;
        tick();
        chk("rst2_gnt", 32'(gnt2), 32'h4);
        req = '0;
        tick();
        tick();
        chk("rst2_valid_due", 32'(rd_valid2), 32'h1);
        chk("rst2_id_due",    32'(rd_id2), 32'h2);
        chk("rst2_data_due",  32'(rd_data2), 32'(romf(12'h3C9)));
        reset_n = 1'b0;
        #1;
        chk("rst2_now_valid", 32'(rd_valid2), 32'h0);
        chk("rst2_now_id",    32'(rd_id2), 32'h0);
        chk("rst2_now_gnt",   32'(gnt2), 32'h0);
        chk("rst2_now_addr",  32'(rom_address2), 32'h0);
        chk("rst2_now_busy",  32'(busy2), 32'h0);
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst2_quiet_valid", 32'(rd_valid2), 32'h0);
            chk("rst2_quiet_busy",  32'(busy2), 32'h0);
        end
        set_addr(1, 12'h5A7);
        req = 4'b0010;
        tick();
        chk("rst2_new_gnt", 32'(gnt2), 32'h2);
        req = '0;
        tick();
        tick();
        chk("rst2_new_valid", 32'(rd_valid2), 32'h1);
        chk("rst2_new_id",    32'(rd_id2), 32'h1);
        chk("rst2_new_data",  32'(rd_data2), 32'(romf(12'h5A7)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
